// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. After reset it reads the 16-bit reset vector, then
// fetches each instruction one byte at a time from a synchronous memory (one
// read in flight at most), sizes it from the opcode and hands the bundle
// {opcode, operand, length, pc} to decode over a valid/ready handshake.
// Execute can redirect the PC at any time once the vector has been loaded.
//
// Optional feature macro: FETCH_HLT_EN
//   defined   : opcode 8'hFF halts fetch after its bundle is accepted; only a
//               redirect or reset leaves the halt state.
//   undefined : 8'hFF is an ordinary one-byte opcode; halted is tied low.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   mem_addr     out  [15:0] read address, meaningful while mem_rd=1 (0 otherwise)
//   mem_rd       out  read strobe, data returns on mem_rdata one cycle later
//   mem_rdata    in   [7:0] read data
//   out_valid    out  bundle valid
//   out_ready    in   downstream accepts when out_valid & out_ready
//   out_instr    out  [7:0] opcode byte
//   out_operand  out  [15:0] operand {hi,lo}; zero-extended for len 2, 0 for len 1
//   out_len      out  [1:0] instruction length 1..3
//   out_pc       out  [15:0] address of the opcode byte
//   redirect     in   load redirect_pc and abort the current fetch
//   redirect_pc  in   [15:0] redirect target
//   halted       out  fetch stopped on HLT
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_instr,
    output logic [15:0] out_operand,
    output logic [1:0]  out_len,
    output logic [15:0] out_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_VEC_LO = 3'd0,
        S_VEC_HI = 3'd1,
        S_OPC    = 3'd2,
        S_OPL    = 3'd3,
        S_OPH    = 3'd4,
        S_VALID  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instruction length decode: the explicit one-byte list takes priority
    // over the three-byte pattern rules (FF would otherwise match [4:2]=7).
    function automatic logic [1:0] len_of(input logic [7:0] op);
        case (op)
            8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58,
            8'h60, 8'h68, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
            8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA,
            8'hF8, 8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'hFF: len_of = 2'd1;
            default: begin
                if (op == 8'h20 || op[4:2] == 3'd3 || op[4:2] == 3'd7 ||
                    (op[1:0] == 2'b01 && op[4:2] == 3'd6))
                    len_of = 2'd3;
                else
                    len_of = 2'd2;
            end
        endcase
    endfunction

    state_t      r_state, w_state_next;
    logic        r_cap, w_cap_next;     // 0 = issue cycle, 1 = capture cycle
    logic        r_started;             // holds the first issue off for one cycle after reset
    logic [15:0] r_pc;
    logic [7:0]  r_vec_lo;
    logic [7:0]  r_instr;
    logic [15:0] r_operand;
    logic [1:0]  r_len;
    logic [15:0] r_out_pc;

    logic        w_fetch;
    logic        w_redirect;
    logic        w_accept;
    logic [1:0]  w_len;

    assign w_fetch    = (r_state == S_VEC_LO) || (r_state == S_VEC_HI) ||
                        (r_state == S_OPC) || (r_state == S_OPL) || (r_state == S_OPH);
    // Redirects are meaningless until the vector has produced a PC.
    assign w_redirect = redirect && (r_state != S_VEC_LO) && (r_state != S_VEC_HI);
    assign w_accept   = (r_state == S_VALID) && out_ready;
    assign w_len      = len_of(mem_rdata);

    // State register and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_VEC_LO;
            r_cap     <= 1'b0;
            r_started <= 1'b0;
            r_pc      <= 16'h0000;
            r_vec_lo  <= 8'h00;
            r_instr   <= 8'h00;
            r_operand <= 16'h0000;
            r_len     <= 2'd0;
            r_out_pc  <= 16'h0000;
        end else begin
            r_state   <= w_state_next;
            r_cap     <= w_cap_next;
            r_started <= 1'b1;
            if (w_redirect) begin
                // In-flight capture is dropped; only the PC is reloaded.
                r_pc <= redirect_pc;
            end else if (r_started && r_cap) begin
                case (r_state)
                    S_VEC_LO: r_vec_lo <= mem_rdata;
                    S_VEC_HI: r_pc     <= {mem_rdata, r_vec_lo};
                    S_OPC: begin
                        r_instr   <= mem_rdata;
                        r_out_pc  <= r_pc;
                        r_pc      <= r_pc + 16'd1;
                        r_len     <= w_len;
                        r_operand <= 16'h0000;
                    end
                    S_OPL: begin
                        r_operand[7:0] <= mem_rdata;
                        r_pc           <= r_pc + 16'd1;
                    end
                    S_OPH: begin
                        r_operand[15:8] <= mem_rdata;
                        r_pc            <= r_pc + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cap_next   = r_cap;
        if (!r_started) begin
            w_state_next = r_state;
        end else if (w_redirect) begin
            // Redirect beats a simultaneous accept; the accept still consumed the bundle.
            w_state_next = S_OPC;
            w_cap_next   = 1'b0;
        end else if (w_fetch) begin
            if (!r_cap) begin
                w_cap_next = 1'b1;
            end else begin
                w_cap_next = 1'b0;
                case (r_state)
                    S_VEC_LO: w_state_next = S_VEC_HI;
                    S_VEC_HI: w_state_next = S_OPC;
                    S_OPC:    w_state_next = (w_len == 2'd1) ? S_VALID : S_OPL;
                    S_OPL:    w_state_next = (r_len == 2'd2) ? S_VALID : S_OPH;
                    S_OPH:    w_state_next = S_VALID;
                    default:  w_state_next = r_state;
                endcase
            end
        end else if (w_accept) begin
`ifdef FETCH_HLT_EN
            w_state_next = (r_instr == 8'hFF) ? S_HALT : S_OPC;
`else
            w_state_next = S_OPC;
`endif
            w_cap_next   = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        mem_rd   = r_started && w_fetch && !r_cap;
        mem_addr = 16'h0000;
        if (mem_rd) begin
            case (r_state)
                S_VEC_LO: mem_addr = RESET_VECTOR;
                S_VEC_HI: mem_addr = RESET_VECTOR + 16'd1;
                default:  mem_addr = r_pc;
            endcase
        end
        out_valid   = (r_state == S_VALID);
        out_instr   = r_instr;
        out_operand = r_operand;
        out_len     = r_len;
        out_pc      = r_out_pc;
`ifdef FETCH_HLT_EN
        halted      = (r_state == S_HALT);
`else
        halted      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_instr;
    logic [15:0] out_operand;
    logic [1:0]  out_len;
    logic [15:0] out_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    fetch_unit #(.RESET_VECTOR(16'hFFFC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_operand (out_operand),
        .out_len     (out_len),
        .out_pc      (out_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model: data one cycle after the strobe.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  instr;
        logic [15:0] operand;
        logic [1:0]  len;
    } bundle_t;

    bundle_t exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Place an instruction in memory and queue the bundle decode should see.
    task automatic load(input logic [15:0] pc, input logic [7:0] op,
                        input logic [15:0] opnd, input logic [1:0] len);
        bundle_t b;
        logic [15:0] a1, a2;
        a1 = pc + 16'd1;
        a2 = pc + 16'd2;
        mem[pc] = op;
        if (len >= 2'd2) mem[a1] = opnd[7:0];
        if (len == 2'd3) mem[a2] = opnd[15:8];
        b.pc = pc; b.instr = op; b.operand = opnd; b.len = len;
        exp_q.push_back(b);
    endtask

    // Bounded wait for a read of a given address; the final observation is compared.
    task automatic wait_addr(input logic [15:0] a, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_rd && mem_addr == a) && n < 200);
        check(tag, {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, a});
    endtask

    // Scoreboard: every accepted bundle is compared with the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            bundle_t e;
            check("bundle_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("pc@%h", e.pc),      {16'd0, out_pc},      {16'd0, e.pc});
                check($sformatf("instr@%h", e.pc),   {24'd0, out_instr},   {24'd0, e.instr});
                check($sformatf("operand@%h", e.pc), {16'd0, out_operand}, {16'd0, e.operand});
                check($sformatf("len@%h", e.pc),     {30'd0, out_len},     {30'd0, e.len});
            end
        end
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        load(16'h8000, 8'hA9, 16'h0042, 2'd2);
        load(16'h8002, 8'h4C, 16'h1234, 2'd3);
        load(16'h8005, 8'hEA, 16'h0000, 2'd1);
        mem[16'h8006] = 8'hA9;               // aborted by redirect, never delivered
        mem[16'h8007] = 8'h77;
        load(16'hC000, 8'hA2, 16'h0055, 2'd2);
        load(16'hC002, 8'h20, 16'hABCD, 2'd3);
        load(16'hC005, 8'hEA, 16'h0000, 2'd1);
        load(16'hFFFF, 8'hEA, 16'h0000, 2'd1);
        load(16'h0000, 8'hFF, 16'h0000, 2'd1);
`ifndef FETCH_HLT_EN
        load(16'h0001, 8'hEA, 16'h0000, 2'd1);
`endif

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
        check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_bus",   {out_instr, out_operand, out_len, 6'd0}, 32'd0);
        check("rst_out_pc",    {16'd0, out_pc},    32'd0);
        check("rst_halted",    {31'd0, halted},    32'd0);

        // Vector fetch, first opcode read at cycle 4, len2 bundle 4 cycles later
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) check("vec_lo_read", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'hFFFC});
            if (k == 1) check("vec_lo_capture_rd", {31'd0, mem_rd}, 32'd0);
            if (k == 2) check("vec_hi_read", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'hFFFD});
            if (k == 4) check("first_opc_read", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h8000});
            if (k == 7) check("len2_not_yet_valid", {31'd0, out_valid}, 32'd0);
            if (k == 8) check("len2_valid_at_4", {31'd0, out_valid}, 32'd1);
        end

        // Back-pressure: outputs hold, no memory traffic
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_no_rd", {31'd0, mem_rd}, 32'd0);
            check("stall_hold",  {out_instr, out_operand, out_len, 6'd0},
                                 {8'hA9, 16'h0042, 2'd2, 6'd0});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("after_accept_read", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h8002});

        // Redirect during the operand-low capture of the A9 at 8006
        wait_addr(16'h8007, "reach_opl_8007");
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'hC000;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        check("redir_no_valid", {31'd0, out_valid}, 32'd0);
        check("redir_read_c000", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'hC000});

        // Redirect to FFFF; fetch must wrap to 0000
        wait_addr(16'hC006, "reach_opc_c006");
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        check("redir_read_ffff", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'hFFFF});
        wait_addr(16'h0000, "wrap_read_0000");

        // Drain the scoreboard, then stop accepting
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1 out_ready = 1'b0;

`ifdef FETCH_HLT_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hlt_halted", {31'd0, halted}, 32'd1);
            check("hlt_no_rd",  {31'd0, mem_rd}, 32'd0);
        end
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h8000;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        check("hlt_released", {31'd0, halted}, 32'd0);
        check("hlt_redir_read", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h8000});
`else
        repeat (4) @(negedge clk);
        check("ff_no_halt", {31'd0, halted}, 32'd0);
        check("ff_fetch_continues", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'h0002});
`endif

        // Reset mid-operation acts immediately, then the vector fetch restarts
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_rd",    {31'd0, mem_rd},    32'd0);
        check("midrst_pc",    {16'd0, out_pc},    32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_vec_read", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'hFFFC});

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
